uart_rx_sampler: RTL

//  Serial-to-byte UART receiver; first stage of the receive path. Feeds the RX ring buffer.

---
 rtl/uart_rx_sampler_pkg.sv | 16 +
 rtl/uart_rx_sampler_sync.sv | 25 ++
 rtl/uart_rx_sampler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_pkg.sv
// Shared UART receive constants: FSM state codes and the default bit period.
// No logic; imported by the receive-path modules.
package uart_rx_sampler_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        UART_RX_IDLE   = 3'd0,
        UART_RX_START  = 3'd1,
        UART_RX_DATA   = 3'd2,
        UART_RX_PARITY = 3'd3,
        UART_RX_STOP   = 3'd4,
        UART_RX_BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler_sync.sv
// Generic N-flop synchroniser for asynchronous single-bit inputs, reset to RST_VAL.
// Latency STAGES cycles; no backpressure.
module uart_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined): mid-bit sampling, byte out.
// Latency: flag/frame_err rise SYNC_STAGES+1 cycles after mid-stop; no backpressure.
module uart_rx_sampler
    import uart_rx_sampler_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic       flag,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic                   rxs;
    rx_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [7:0]             data_q, data_d;
    logic                   flag_q, flag_d;
    logic                   ferr_q, ferr_d;
    logic                   prev_q, prev_d;
    logic [SYNC_STAGES-1:0] settle_q, settle_d;
    logic                   settled;
    logic                   start_edge;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
`endif

    uart_rx_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (rxd),
        .q_o  (rxs)
    );

    // The synchroniser is preset high, so a line already low at reset release would
    // look like a falling edge; edges only count once the preset has flushed out.
    assign settled    = settle_q[SYNC_STAGES-1];
    assign start_edge = settled & prev_q & ~rxs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= UART_RX_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            flag_q    <= 1'b0;
            ferr_q    <= 1'b0;
            prev_q    <= 1'b0;
            settle_q  <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            flag_q    <= flag_d;
            ferr_q    <= ferr_d;
            prev_q    <= prev_d;
            settle_q  <= settle_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        flag_d    = 1'b0;
        ferr_d    = 1'b0;
        prev_d    = settled ? rxs : 1'b0;
        settle_d  = {settle_q[SYNC_STAGES-2:0], 1'b1};
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif

        case (state_q)
            UART_RX_IDLE: begin
                if (start_edge) begin
                    state_d = UART_RX_START;
                    cnt_d   = CNT_HALF;
                end
            end
            UART_RX_START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = UART_RX_IDLE;
                    end else begin
                        state_d = UART_RX_DATA;
                        cnt_d   = CNT_FULL;
                        idx_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            UART_RX_DATA: begin
                if (cnt_q == '0) begin
                    shreg_d = {rxs, shreg_q[7:1]};
                    cnt_d   = CNT_FULL;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = UART_RX_PARITY;
`else
                        state_d = UART_RX_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            UART_RX_PARITY: begin
                if (cnt_q == '0) begin
                    par_err_d = (^shreg_q) ^ rxs;
                    cnt_d     = CNT_FULL;
                    state_d   = UART_RX_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            UART_RX_STOP: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = UART_RX_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_err_q) begin
                            ferr_d = 1'b1;
                        end else begin
                            flag_d = 1'b1;
                            data_d = shreg_q;
                        end
`else
                        flag_d = 1'b1;
                        data_d = shreg_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = UART_RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            UART_RX_BREAK: begin
                if (rxs) begin
                    state_d = UART_RX_IDLE;
                end
            end
            default: begin
                state_d = UART_RX_IDLE;
            end
        endcase
    end

    assign flag      = flag_q;
    assign data      = data_q;
    assign frame_err = ferr_q;

endmodule
